// File: rtl/i2c_slave_regfile.sv
// I2C slave with a NUM_REGS x 8 register file: ack address, load pointer byte, auto-increment writes/reads.
// Latency: 3 clk input sync + edge detect, SDA updated the clk after a detected SCL fall; never stretches SCL.
module i2c_slave_regfile #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        DATA_WIDTH     = 8,
    parameter int                        NUM_REGS       = 16,
    localparam int                       PTR_W          = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  wr_stb_o,
    output logic [PTR_W-1:0]      wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_scl_s1, r_scl_s2, r_scl_d;
    logic                  r_sda_s1, r_sda_s2, r_sda_d;
    logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] w_byte, w_rd_cur, r_rd_byte;
    logic [2:0]            w_rd_idx;
    logic                  r_rw, r_ack_on, r_sda, w_sda_nxt, r_busy;
    logic [PTR_W-1:0]      r_ptr, w_ptr_inc;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_wr_stb;
    logic [PTR_W-1:0]      r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    // Synchronizers reset to the idle bus level so reset release never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_rd_cur   = r_regs[r_ptr];
    assign w_rd_idx   = ~r_cnt[2:0];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sda   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sda   <= w_sda_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:
                    if (w_scl_rise && r_cnt == 4'd7)
                        w_state_nxt = (w_byte[DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:
                    if (w_scl_fall && r_ack_on) w_state_nxt = r_rw ? S_RD_DATA : S_PTR;
                S_PTR:
                    if (w_scl_rise && r_cnt == 4'd7) w_state_nxt = S_PTR_ACK;
                S_PTR_ACK, S_WR_ACK:
                    if (w_scl_fall && r_ack_on) w_state_nxt = S_WR_DATA;
                S_WR_DATA:
                    if (w_scl_rise && r_cnt == 4'd7) w_state_nxt = S_WR_ACK;
                S_RD_DATA:
                    if (w_scl_fall && r_cnt == 4'd8) w_state_nxt = S_RD_ACK;
                S_RD_ACK:
                    if (w_scl_rise) w_state_nxt = r_sda_s2 ? S_IGNORE : S_RD_DATA;
                default: ;
            endcase
        end
    end

    // Ack states hold SDA low across one full SCL low/high/low window: first fall pulls, second releases.
    always_comb begin
        w_sda_nxt = r_sda;
        if (w_start || w_stop) begin
            w_sda_nxt = 1'b1;
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR_ACK:          w_sda_nxt = r_ack_on ? (r_rw ? w_rd_cur[DATA_WIDTH-1] : 1'b1) : 1'b0;
                S_PTR_ACK, S_WR_ACK: w_sda_nxt = r_ack_on;
                S_RD_DATA:           w_sda_nxt = (r_cnt == 4'd8) ? 1'b1 : r_rd_byte[w_rd_idx];
                default:             w_sda_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else if (w_stop) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_ack_on  <= 1'b0;
            r_ptr     <= '0;
            r_rd_byte <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start || w_stop) begin
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WR_DATA:
                        if (w_scl_rise) begin
                            r_shift <= w_byte[DATA_WIDTH-2:0];
                            r_cnt   <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                if (r_state == S_ADDR) r_rw <= r_sda_s2;
                                if (r_state == S_PTR)  r_ptr <= w_byte[PTR_W-1:0];
                                if (r_state == S_WR_DATA) begin
                                    r_regs[r_ptr] <= w_byte;
                                    r_wr_stb      <= 1'b1;
                                    r_wr_addr     <= r_ptr;
                                    r_wr_data     <= w_byte;
                                    r_ptr         <= w_ptr_inc;
                                end
                            end
                        end
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK:
                        if (w_scl_fall) begin
                            r_ack_on <= ~r_ack_on;
                            if (r_ack_on) r_rd_byte <= w_rd_cur;
                        end
                    S_RD_DATA:
                        if (w_scl_rise) r_cnt <= r_cnt + 4'd1;
                        else if (w_scl_fall && r_cnt == 4'd8) r_cnt <= '0;
                    S_RD_ACK:
                        if (w_scl_rise && !r_sda_s2) begin
                            r_ptr     <= w_ptr_inc;
                            r_rd_byte <= r_regs[w_ptr_inc];
                        end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o     = r_sda;
    assign busy_o    = r_busy;
    assign wr_stb_o  = r_wr_stb;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

endmodule
